// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: fetches an opcode byte and up to MAX_OPERAND_BYTES
// little-endian operand bytes, then presents the instruction with a valid/accept handshake.
module fetch_unit #(
    parameter int unsigned          WORD_SIZE         = 16,
    parameter int unsigned          DATA_WIDTH        = 8,
    parameter int unsigned          MAX_OPERAND_BYTES = 2,
    parameter logic [WORD_SIZE-1:0] RESET_PC          = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [WORD_SIZE-1:0]  addr_bus,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  read_en,
    input  logic                  mem_ready,
    output logic [DATA_WIDTH-1:0] opcode,
    output logic [WORD_SIZE-1:0]  operand,
    output logic [1:0]            operand_bytes,
    output logic                  instr_valid,
    input  logic                  instr_accept,
    input  logic                  redirect,
    input  logic [WORD_SIZE-1:0]  redirect_pc,
    output logic [WORD_SIZE-1:0]  pc
);

    localparam logic [1:0]           MAX_BYTES = 2'(MAX_OPERAND_BYTES);
    localparam logic [WORD_SIZE-1:0] PC_INC    = {{(WORD_SIZE-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, FETCH_OP, FETCH_ARG, HOLD} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [WORD_SIZE-1:0]  r_pc;
    logic [WORD_SIZE-1:0]  r_operand;
    logic [DATA_WIDTH-1:0] r_opcode;
    logic [1:0]            r_nbytes;
    logic [1:0]            r_idx;
    logic                  r_valid;
    logic [1:0]            w_len_field;
    logic [1:0]            w_new_nbytes;
    logic                  w_fetching;
    logic                  w_xfer;

    // Operand length comes from the two top bits of the opcode, clamped to the supported maximum.
    always_comb begin
        w_len_field  = data_in[DATA_WIDTH-1 -: 2];
        w_new_nbytes = (w_len_field > MAX_BYTES) ? MAX_BYTES : w_len_field;
        w_fetching   = (r_state == FETCH_OP) || (r_state == FETCH_ARG);
        w_xfer       = w_fetching && mem_ready && !redirect;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      w_next = FETCH_OP;
            FETCH_OP: begin
                if (redirect)
                    w_next = FETCH_OP;
                else if (mem_ready)
                    w_next = (w_new_nbytes == 2'd0) ? HOLD : FETCH_ARG;
            end
            FETCH_ARG: begin
                if (redirect)
                    w_next = FETCH_OP;
                else if (mem_ready && (r_idx == r_nbytes - 2'd1))
                    w_next = HOLD;
            end
            HOLD: begin
                if (redirect || instr_accept)
                    w_next = FETCH_OP;
            end
            default:   w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_next;
            r_valid <= (w_next == HOLD);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc      <= RESET_PC;
            r_opcode  <= '0;
            r_operand <= '0;
            r_nbytes  <= '0;
            r_idx     <= '0;
        end else begin
            if (redirect && (r_state != IDLE))
                r_pc <= redirect_pc;
            else if (w_xfer)
                r_pc <= r_pc + PC_INC;

            if (w_xfer) begin
                if (r_state == FETCH_OP) begin
                    r_opcode  <= data_in;
                    r_operand <= '0;
                    r_nbytes  <= w_new_nbytes;
                    r_idx     <= '0;
                end else begin
                    // Constant-sliced writes keep every lane index in range for any legal parameter set.
                    for (int unsigned k = 0; k < MAX_OPERAND_BYTES; k++) begin
                        if (32'(r_idx) == k)
                            r_operand[k*DATA_WIDTH +: DATA_WIDTH] <= data_in;
                    end
                    r_idx <= r_idx + 2'd1;
                end
            end
        end
    end

    assign addr_bus      = r_pc;
    assign pc            = r_pc;
    assign read_en       = w_fetching;
    assign opcode        = r_opcode;
    assign operand       = r_operand;
    assign operand_bytes = r_nbytes;
    assign instr_valid   = r_valid;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Parametrised instruction fetch sequencer for the CPU core.
- Generalises the fixed PC/IR/AR fetch path to configurable address width, data width and variable-length instructions: one opcode byte plus 0..MAX_OPERAND_BYTES operand bytes, assembled into a WORD_SIZE operand.
- Sits between the external memory bus and the control/execute stage.
- Adds what the fixed path lacks: a memory wait-state handshake, a valid/accept handoff to execute, and PC redirect for branches.

Parameters:
- WORD_SIZE, 16: address bus, PC and operand width. Must be a multiple of DATA_WIDTH.
- DATA_WIDTH, 8: memory data bus and opcode width. Must be >= 2.
- MAX_OPERAND_BYTES, 2: maximum operand bytes per instruction. Legal range 0..3, and MAX_OPERAND_BYTES*DATA_WIDTH <= WORD_SIZE.
- RESET_PC, 0: PC value loaded on reset.

Ports:
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  asynchronous, active-low reset
- addr_bus  out  WORD_SIZE  memory address; equals pc
- data_in  in  DATA_WIDTH  memory read data
- read_en  out  1  memory read request
- mem_ready  in  1  memory has data_in valid this cycle
- opcode  out  DATA_WIDTH  fetched opcode
- operand  out  WORD_SIZE  assembled operand, zero-extended
- operand_bytes  out  2  number of operand bytes in current instruction
- instr_valid  out  1  opcode/operand/operand_bytes hold a complete instruction
- instr_accept  in  1  execute stage consumes the instruction
- redirect  in  1  load new PC, flush fetch
- redirect_pc  in  WORD_SIZE  target PC for redirect
- pc  out  WORD_SIZE  current fetch address

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, pc=RESET_PC, opcode=0, operand=0, operand_bytes=0, instr_valid=0.
  - read_en=0 while reset is low and in IDLE.
- States:
  - IDLE: one cycle, then FETCH_OP.
  - FETCH_OP: fetch the opcode byte.
  - FETCH_ARG: fetch operand bytes.
  - HOLD: instruction presented to execute.
- Bus signals:
  - read_en=1 exactly in FETCH_OP and FETCH_ARG; combinational from state.
  - addr_bus=pc at all times.
- Transfer rule: in FETCH_OP or FETCH_ARG, a clock edge with mem_ready=1 captures data_in and sets pc <= pc+1. PC wraps modulo 2^WORD_SIZE (all-ones goes to 0).
- Stall: mem_ready=0 holds state, pc and all captured data unchanged. There is no timeout.
- FETCH_OP capture:
  - opcode <= data_in; operand <= 0; byte index <= 0.
  - operand_bytes <= min(data_in[DATA_WIDTH-1:DATA_WIDTH-2], MAX_OPERAND_BYTES).
  - If operand_bytes is 0, go to HOLD; otherwise go to FETCH_ARG.
- FETCH_ARG capture:
  - Operand is little-endian: byte k is written to operand[k*DATA_WIDTH +: DATA_WIDTH].
  - Index increments; after the last byte, go to HOLD.
- HOLD:
  - instr_valid=1, registered; asserted exactly while in HOLD.
  - Outputs are stable until accepted.
  - instr_accept=1 at an edge: go to FETCH_OP, and instr_valid is 0 the next cycle.
  - instr_accept is ignored outside HOLD.
- Latency: with zero wait states, an instruction with n operand bytes reaches instr_valid n+1 cycles after read_en first rises. The minimum back-to-back spacing is n+2 cycles.
- Redirect:
  - In any state except IDLE, redirect=1 at an edge sets pc <= redirect_pc, state <= FETCH_OP, instr_valid <= 0.
  - Any partially fetched instruction is discarded; opcode, operand and operand_bytes may retain stale values.
  - redirect has priority over mem_ready capture and over instr_accept in the same cycle. A simultaneous accept in HOLD counts as consumed.
  - redirect is ignored in IDLE.
- Reset mid-fetch: reset immediately returns all state to reset values; no bus transfer completes.

Test Plan:
- Reset release, memory bytes 0x01 at 0x0000, mem_ready=1, instr_accept=1:
  - read_en low during IDLE, high the next cycle.
  - instr_valid=1 with opcode=0x01, operand=0, operand_bytes=0, pc=0x0001.
- Memory 0x80,0x34,0x12 at 0x0000:
  - instr_valid 3 cycles after read_en first rises.
  - opcode=0x80, operand=0x1234, operand_bytes=2, pc=0x0003.
- Same memory as the previous case, mem_ready low for 2 cycles before each byte:
  - Identical result; instr_valid 9 cycles after read_en first rises.
  - pc never increments on stalled cycles.
- Hold instr_accept=0 for 5 cycles in HOLD:
  - instr_valid, opcode and operand stay constant.
  - read_en=0; pc unchanged.
  - Accept, then fetch resumes at pc on the next cycle.
- redirect=1 with redirect_pc=0x4000 while fetching the second operand byte of 0x80 with mem_ready=1:
  - Byte not captured; pc=0x4000; state FETCH_OP; instr_valid=0.
  - The next instruction comes from 0x4000.
- Start fetch with pc=0xFFFF via redirect, opcode 0x40 at 0xFFFF, 0xAB at 0x0000:
  - operand=0x00AB, operand_bytes=1.
  - pc wraps to 0x0001.
